// File: rtl/rotate_fb_sched_if.sv
// Frame-event and bank-status bundle between the frame writer/reader and the
// triple-buffer scheduler. The master side raises the pulses, the slave
// side reports bank ownership and counters.
interface rotate_fb_sched_if #(
    parameter int AW = 18
);
    logic          wr_frame_start;
    logic          wr_frame_done;
    logic          rd_frame_start;
    logic [1:0]    wr_bank;
    logic [1:0]    rd_bank;
    logic [AW-1:0] wr_base;
    logic [AW-1:0] rd_base;
    logic          wr_active;
    logic          rd_valid;
    logic [7:0]    drop_cnt;
    logic [7:0]    repeat_cnt;

    modport master (
        output wr_frame_start, wr_frame_done, rd_frame_start,
        input  wr_bank, rd_bank, wr_base, rd_base, wr_active, rd_valid,
               drop_cnt, repeat_cnt
    );

    modport slave (
        input  wr_frame_start, wr_frame_done, rd_frame_start,
        output wr_bank, rd_bank, wr_base, rd_base, wr_active, rd_valid,
               drop_cnt, repeat_cnt
    );
endinterface

// File: rtl/rotate_fb_sched.sv
// Triple-buffer bank scheduler for a rotated frame buffer. The writer always
// fills a bank that the reader is not scanning and that does not hold the
// pending ready frame; late frames are dropped, starved reads repeat.
module rotate_fb_sched #(
    parameter int BUFSIZE = 76800,
    parameter int AW      = 18
) (
    input  logic               clk,
    input  logic               reset,
    rotate_fb_sched_if.slave   bus
);
    localparam logic [0:0] W_IDLE   = 1'b0;
    localparam logic [0:0] W_ACTIVE = 1'b1;

    logic [1:0] wr_bank, rd_bank, ready_bank;
    logic       ready_valid, rd_valid;
    logic [0:0] wr_state;
    logic [7:0] drop_cnt, repeat_cnt;
    logic [AW-1:0] wr_base, rd_base;

    logic [1:0] wr_bank_n, rd_bank_n, ready_bank_n;
    logic       ready_valid_n, rd_valid_n;
    logic [0:0] wr_state_n;
    logic       drop_inc, repeat_inc;

    function automatic logic [AW-1:0] bank_base(input logic [1:0] b);
        case (b)
            2'd1:    bank_base = AW'(BUFSIZE);
            2'd2:    bank_base = AW'(2 * BUFSIZE);
            default: bank_base = '0;
        endcase
    endfunction

    // Events resolved in order done -> read start -> write start, each stage
    // seeing the previous stage's result, so same-cycle combinations hand the
    // just-completed frame straight to the reader and pick a fresh bank after.
    always_comb begin
        wr_bank_n     = wr_bank;
        rd_bank_n     = rd_bank;
        ready_bank_n  = ready_bank;
        ready_valid_n = ready_valid;
        wr_state_n    = wr_state;
        rd_valid_n    = rd_valid;
        drop_inc      = 1'b0;
        repeat_inc    = 1'b0;

        if (bus.wr_frame_done && wr_state_n == W_ACTIVE) begin
            // a still-pending ready frame is overwritten by the newer one
            if (ready_valid_n) drop_inc = 1'b1;
            ready_bank_n  = wr_bank_n;
            ready_valid_n = 1'b1;
            wr_state_n    = W_IDLE;
        end

        if (bus.rd_frame_start) begin
            if (ready_valid_n) begin
                rd_bank_n     = ready_bank_n;
                ready_valid_n = 1'b0;
                rd_valid_n    = 1'b1;
            end else if (rd_valid_n) begin
                repeat_inc = 1'b1;
            end
        end

        if (bus.wr_frame_start) begin
            if (wr_state_n == W_IDLE) begin
                // banks sum to 3, so the one owned by neither reader nor
                // ready slot is 3 - rd - ready
                if (ready_valid_n)
                    wr_bank_n = 2'd3 - rd_bank_n - ready_bank_n;
                else
                    wr_bank_n = (rd_bank_n == 2'd2) ? 2'd0 : rd_bank_n + 2'd1;
                wr_state_n = W_ACTIVE;
            end else begin
                // writer restarted without finishing: partial frame lost
                drop_inc = 1'b1;
            end
        end
    end

    // State, counters and bank bases all update together on the clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_bank     <= 2'd1;
            rd_bank     <= 2'd0;
            ready_bank  <= 2'd2;
            ready_valid <= 1'b0;
            rd_valid    <= 1'b0;
            wr_state    <= W_IDLE;
            drop_cnt    <= 8'd0;
            repeat_cnt  <= 8'd0;
            wr_base     <= AW'(BUFSIZE);
            rd_base     <= '0;
        end else begin
            wr_bank     <= wr_bank_n;
            rd_bank     <= rd_bank_n;
            ready_bank  <= ready_bank_n;
            ready_valid <= ready_valid_n;
            rd_valid    <= rd_valid_n;
            wr_state    <= wr_state_n;
            wr_base     <= bank_base(wr_bank_n);
            rd_base     <= bank_base(rd_bank_n);
            if (drop_inc && drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 8'd1;
            if (repeat_inc && repeat_cnt != 8'hFF)
                repeat_cnt <= repeat_cnt + 8'd1;
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        bus.wr_bank    = wr_bank;
        bus.rd_bank    = rd_bank;
        bus.wr_base    = wr_base;
        bus.rd_base    = rd_base;
        bus.wr_active  = (wr_state == W_ACTIVE);
        bus.rd_valid   = rd_valid;
        bus.drop_cnt   = drop_cnt;
        bus.repeat_cnt = repeat_cnt;
    end
endmodule

// File: tb/tb_rotate_fb_sched.sv
// Bench for rotate_fb_sched: vector table, directed corner sequences and a
// randomized pulse stream against a bank-ownership reference model.
module tb_rotate_fb_sched;
    localparam int BUFSIZE = 76800;
    localparam int AW      = 18;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fail   = 0;

    rotate_fb_sched_if #(.AW(AW)) bus ();

    rotate_fb_sched #(.BUFSIZE(BUFSIZE), .AW(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int d, r, s;
        int wb, rdb, act, rdv, drop, rep;
    } vec_t;

    vec_t tbl[12];

    // reference model state
    int m_wb, m_rdb, m_rb, m_rv, m_act, m_rdv, m_drop, m_rep;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int wb, input int rdb, input int act,
                           input int rdv, input int drop, input int rep);
        chk({tag, " wr_bank"},    int'(bus.wr_bank), wb);
        chk({tag, " rd_bank"},    int'(bus.rd_bank), rdb);
        chk({tag, " wr_base"},    int'(bus.wr_base), wb * BUFSIZE);
        chk({tag, " rd_base"},    int'(bus.rd_base), rdb * BUFSIZE);
        chk({tag, " wr_active"},  int'(bus.wr_active), act);
        chk({tag, " rd_valid"},   int'(bus.rd_valid), rdv);
        chk({tag, " drop_cnt"},   int'(bus.drop_cnt), drop);
        chk({tag, " repeat_cnt"}, int'(bus.repeat_cnt), rep);
    endtask

    // Pulses are raised just after one rising edge and consumed by the next.
    task automatic step(input int d, input int r, input int s);
        bus.wr_frame_done  = 1'(d);
        bus.rd_frame_start = 1'(r);
        bus.wr_frame_start = 1'(s);
        @(posedge clk);
        #1;
        bus.wr_frame_done  = 1'b0;
        bus.rd_frame_start = 1'b0;
        bus.wr_frame_start = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        #3 reset = 1'b0;
        m_wb = 1; m_rdb = 0; m_rb = 2; m_rv = 0; m_act = 0; m_rdv = 0;
        m_drop = 0; m_rep = 0;
    endtask

    // Writer gets whichever bank is owned by neither the reader nor a pending
    // ready frame; with no pending frame the bank after the reader is used.
    function automatic int pick_free(input int rdb, input int rb, input int rv);
        int f;
        f = (rdb + 1) % 3;
        if (rv != 0)
            for (int b = 0; b < 3; b++)
                if (b != rdb && b != rb) f = b;
        return f;
    endfunction

    task automatic model_step(input int d, input int r, input int s);
        if (d != 0 && m_act != 0) begin
            if (m_rv != 0) m_drop = (m_drop < 255) ? m_drop + 1 : 255;
            m_rb = m_wb; m_rv = 1; m_act = 0;
        end
        if (r != 0) begin
            if (m_rv != 0) begin
                m_rdb = m_rb; m_rv = 0; m_rdv = 1;
            end else if (m_rdv != 0) begin
                m_rep = (m_rep < 255) ? m_rep + 1 : 255;
            end
        end
        if (s != 0) begin
            if (m_act == 0) begin
                m_wb = pick_free(m_rdb, m_rb, m_rv); m_act = 1;
            end else begin
                m_drop = (m_drop < 255) ? m_drop + 1 : 255;
            end
        end
    endtask

    initial begin
        int ok;
        bus.wr_frame_done  = 1'b0;
        bus.rd_frame_start = 1'b0;
        bus.wr_frame_start = 1'b0;

        //            d r s  wb rdb act rdv drop rep
        tbl[0]  = '{0, 0, 1, 1, 0, 1, 0, 0, 0};
        tbl[1]  = '{1, 0, 0, 1, 0, 0, 0, 0, 0};
        tbl[2]  = '{0, 1, 0, 1, 1, 0, 1, 0, 0};
        tbl[3]  = '{0, 1, 0, 1, 1, 0, 1, 0, 1};
        tbl[4]  = '{0, 0, 1, 2, 1, 1, 1, 0, 1};
        tbl[5]  = '{1, 1, 1, 0, 2, 1, 1, 0, 1};
        tbl[6]  = '{0, 0, 1, 0, 2, 1, 1, 1, 1};
        tbl[7]  = '{1, 0, 0, 0, 2, 0, 1, 1, 1};
        tbl[8]  = '{0, 0, 1, 1, 2, 1, 1, 1, 1};
        tbl[9]  = '{1, 0, 1, 0, 2, 1, 1, 2, 1};
        tbl[10] = '{1, 1, 0, 0, 0, 0, 1, 3, 1};
        tbl[11] = '{0, 1, 0, 0, 0, 0, 1, 3, 2};

        // reset values, checked while reset is still held
        #2 reset = 1'b1;
        #1 chk_all("reset", 1, 0, 0, 0, 0, 0);
        #3 reset = 1'b0;

        // vector table from a fresh reset
        do_reset();
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].d, tbl[i].r, tbl[i].s);
            chk_all($sformatf("vec%0d", i), tbl[i].wb, tbl[i].rdb, tbl[i].act,
                    tbl[i].rdv, tbl[i].drop, tbl[i].rep);
        end

        // first frame handed to the reader, then starved repeats to saturation
        do_reset();
        step(0, 0, 1);
        chk_all("first_start", 1, 0, 1, 0, 0, 0);
        step(1, 0, 0);
        chk("first_done wr_active", int'(bus.wr_active), 0);
        step(0, 1, 0);
        chk_all("first_read", 1, 1, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 0);
        chk_all("repeat4", 1, 1, 0, 1, 0, 4);
        for (int i = 0; i < 300; i++) step(0, 1, 0);
        chk_all("repeat_sat", 1, 1, 0, 1, 0, 255);

        // three frames with no reader: writer alternates around the reader
        step(0, 0, 1); chk("frameA wr_bank", int'(bus.wr_bank), 2);
        step(1, 0, 0);
        step(0, 0, 1); chk("frameB wr_bank", int'(bus.wr_bank), 0);
        step(1, 0, 0);
        step(0, 0, 1); chk("frameC wr_bank", int'(bus.wr_bank), 2);
        step(1, 0, 0);
        chk_all("no_reader", 2, 1, 0, 1, 2, 255);

        // abandoned frame then asynchronous reset mid-frame
        do_reset();
        step(0, 0, 1);
        step(0, 0, 1);
        chk_all("abandon", 1, 0, 1, 0, 1, 0);
        #2 reset = 1'b1;
        #1 chk_all("async_reset", 1, 0, 0, 0, 0, 0);
        bus.wr_frame_start = 1'b1;
        bus.rd_frame_start = 1'b1;
        @(posedge clk);
        #1;
        bus.wr_frame_start = 1'b0;
        bus.rd_frame_start = 1'b0;
        chk_all("pulse_in_reset", 1, 0, 0, 0, 0, 0);
        reset = 1'b0;

        // random pulse stream against the reference model
        do_reset();
        for (int c = 0; c < 10000; c++) begin
            int d, r, s;
            d = ($urandom_range(0, 3) == 0) ? 1 : 0;
            r = ($urandom_range(0, 3) == 0) ? 1 : 0;
            s = ($urandom_range(0, 3) == 0) ? 1 : 0;
            step(d, r, s);
            model_step(d, r, s);
            ok = (int'(bus.wr_bank) == m_wb && int'(bus.rd_bank) == m_rdb &&
                  int'(bus.wr_base) == m_wb * BUFSIZE &&
                  int'(bus.rd_base) == m_rdb * BUFSIZE &&
                  int'(bus.wr_active) == m_act && int'(bus.rd_valid) == m_rdv &&
                  int'(bus.drop_cnt) == m_drop && int'(bus.repeat_cnt) == m_rep) ? 1 : 0;
            if (ok == 0)
                $display("FAIL rand c%0d: got wb%0d rdb%0d act%0d rdv%0d drop%0d rep%0d expected wb%0d rdb%0d act%0d rdv%0d drop%0d rep%0d",
                         c, bus.wr_bank, bus.rd_bank, bus.wr_active, bus.rd_valid,
                         bus.drop_cnt, bus.repeat_cnt, m_wb, m_rdb, m_act, m_rdv, m_drop, m_rep);
            chk($sformatf("rand_match c%0d", c), ok, 1);
            // ownership: a writing bank is never the scanned or pending bank,
            // and the pending bank is never the scanned one
            ok = 1;
            if (bus.wr_active && bus.wr_bank == bus.rd_bank) ok = 0;
            if (bus.wr_active && m_rv != 0 && int'(bus.wr_bank) == m_rb) ok = 0;
            if (m_rv != 0 && int'(bus.rd_bank) == m_rb) ok = 0;
            chk($sformatf("rand_owner c%0d", c), ok, 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
